ifetch_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory and the IF stage of the 5-stage MIPS pipeline. It issues sequential word fetches to a variable-latency instruction memory over a request/response handshake, and buffers up to DEPTH returned instructions with their PCs. It presents the oldest entry to IF. A redirect from a taken branch or jump flushes the queue, discards in-flight responses and restarts fetching at the new PC.

---
 rtl/ifetch_prefetch_queue_if.sv | 38 +++
 rtl/ifetch_prefetch_queue.sv | 140 ++++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue_if
// Request/response bus between the instruction prefetch queue and the
// instruction memory. Requests are a valid/ready handshake. Responses have no
// backpressure and return in request order.
//
// Signals:
//   mem_req_valid  queue -> mem   fetch request present
//   mem_req_addr   queue -> mem   word-aligned fetch address
//   mem_req_ready  mem -> queue   memory accepts the request this cycle
//   mem_rsp_valid  mem -> queue   response word valid this cycle
//   mem_rsp_data   mem -> queue   fetched instruction word
//
// Modports: master = prefetch queue side, slave = instruction memory side.
// ----------------------------------------------------------------------------
interface ifetch_prefetch_queue_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_prefetch_queue
// Instruction prefetch queue that sits between the instruction memory and the
// IF stage. It issues sequential word fetches and buffers up to DEPTH returned
// instructions, each tagged with its PC. The oldest entry is presented to IF.
// A redirect flushes the queue, marks every in-flight fetch as stale, and
// restarts fetching at the new PC.
//
// Parameters:
//   DEPTH     queue entries and fetch credit (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//   NOP_WORD  value driven on instr while the queue is empty
//
// Ports:
//   clock, reset   rising-edge clock; asynchronous active-high reset
//   redirect       taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc    new fetch address (low two bits ignored)
//   instr_pop      IF consumes the head entry this cycle
//   instr_valid    head entry present
//   instr          head instruction, NOP_WORD when empty
//   instr_pc       PC of head instruction, 0 when empty
//   mem            master side of the instruction memory bus
// ----------------------------------------------------------------------------
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP_WORD = 32'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic                    instr_pop,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    ifetch_prefetch_queue_if.master mem
);
    localparam int             PTR_W     = $clog2(DEPTH);
    localparam int             CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_addr;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      tag_mem  [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tag_rd_ptr;
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             rsp_take;
    logic             rsp_keep;
    logic             pop_take;

    // Fetch addresses are always word aligned, so the byte-offset bits of the
    // redirect target are deliberately dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Buffered entries and fetches in flight (stale or not) share one credit
    // pool, so the queue can always absorb every response it has asked for.
    assign credit_used       = {1'b0, occupancy} + {1'b0, outstanding};
    assign mem.mem_req_valid = !reset && !redirect && (credit_used < DEPTH_SUM);
    assign mem.mem_req_addr  = fetch_addr;

    assign accept   = mem.mem_req_valid && mem.mem_req_ready;
    // A response with nothing outstanding is a protocol violation and ignored.
    assign rsp_take = mem.mem_rsp_valid && (outstanding != '0);
    // Stale responses, and any response in a redirect cycle, are never stored.
    assign rsp_keep = rsp_take && (discard == '0) && !redirect;
    assign pop_take = instr_pop && instr_valid && !redirect;

    assign instr_valid = (occupancy != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : NOP_WORD;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

    // Control state. Redirect and accept never coincide because a redirect
    // suppresses mem_req_valid, so the fetch_addr updates cannot collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_addr  <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd_ptr  <= '0;
            tag_wr_ptr  <= '0;
            occupancy   <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (accept) begin
                fetch_addr <= fetch_addr + 32'd4;
                tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
            end

            if (redirect) begin
                fetch_addr <= {redirect_pc[31:2], 2'b00};
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                tag_rd_ptr <= '0;
                tag_wr_ptr <= '0;
                occupancy  <= '0;
                // Everything still in flight is stale; a response landing in
                // this same cycle is already accounted for by rsp_take.
                discard    <= outstanding - CNT_W'(rsp_take);
            end else begin
                if (rsp_keep) begin
                    wr_ptr     <= wr_ptr + PTR_W'(1);
                    tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
                end
                if (pop_take) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                occupancy <= occupancy + CNT_W'(rsp_keep) - CNT_W'(pop_take);
                if (rsp_take && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end

            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_take);
        end
    end

    // Storage arrays need no reset: occupancy gates everything visible, and
    // the tag FIFO only holds addresses of non-stale fetches, so its head
    // always belongs to the next response that is kept.
    always_ff @(posedge clock) begin
        if (rsp_keep) begin
            data_mem[wr_ptr] <= mem.mem_rsp_data;
            pc_mem[wr_ptr]   <= tag_mem[tag_rd_ptr];
        end
        if (accept) begin
            tag_mem[tag_wr_ptr] <= fetch_addr;
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_prefetch_queue
// Self-checking bench for ifetch_prefetch_queue (DEPTH=4, RESET_PC=0,
// NOP_WORD=0). A small in-order memory model with programmable latency
// answers fetches; program word at address A is 0x2001_0000 + A/4.
// ----------------------------------------------------------------------------
module tb_ifetch_prefetch_queue;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_pop;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    ifetch_prefetch_queue_if mem_bus();

    ifetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .NOP_WORD (32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_pop   (instr_pop),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .mem         (mem_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = -1;
    int          mem_latency = 1;
    logic        mem_ready   = 1'b1;
    logic        stray_rsp   = 1'b0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    typedef struct {
        logic        pop;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] prog_word(input logic [31:0] addr);
        return 32'h2001_0000 + {2'b00, addr[31:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                     name, cyc, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs and the memory response at the falling
    // edge, let combinational outputs settle, then update the memory model.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                                 input logic pop);
        @(negedge clock);
        cyc++;
        redirect              = redir;
        redirect_pc           = rpc;
        instr_pop             = pop;
        mem_bus.mem_req_ready = mem_ready;
        if (stray_rsp) begin
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_bus.mem_rsp_valid = 1'b1;
            mem_bus.mem_rsp_data  = prog_word(pend_addr[0]);
        end else begin
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rsp_data  = 32'h0;
        end
        #1;
        if (mem_bus.mem_rsp_valid && !stray_rsp) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
            pend_addr.push_back(mem_bus.mem_req_addr);
            pend_due.push_back(cyc + mem_latency);
        end
    endtask

    task automatic doReset();
        reset                 = 1'b1;
        redirect              = 1'b0;
        redirect_pc           = 32'h0;
        instr_pop             = 1'b0;
        stray_rsp             = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_data  = 32'h0;
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        cyc   = -1;
    endtask

    task automatic checkHead(input string name, input logic exp_valid,
                             input logic [31:0] exp_pc);
        checkOutput({name, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, exp_valid});
        checkOutput({name, ".instr_pc"}, instr_pc, exp_valid ? exp_pc : 32'h0);
        checkOutput({name, ".instr"}, instr, exp_valid ? prog_word(exp_pc) : 32'h0);
    endtask

    task automatic checkReq(input string name, input logic exp_valid,
                            input logic [31:0] exp_addr);
        checkOutput({name, ".req_valid"}, {31'b0, mem_bus.mem_req_valid}, {31'b0, exp_valid});
        checkOutput({name, ".req_addr"}, mem_bus.mem_req_addr, exp_addr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fill with 1-cycle memory and no pops (credit stops issue after four
        // requests), then pop continuously for one instruction per cycle.
        //            pop   rv    addr        valid pc
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
        vecs[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[7]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
        vecs[8]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
        vecs[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[14] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};

        doReset();
        #1;
        checkHead("reset", 1'b0, 32'h0);
        checkOutput("reset.req_addr", mem_bus.mem_req_addr, 32'h0);

        mem_latency = 1;
        mem_ready   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 32'h0, vecs[i].pop);
            checkReq($sformatf("fill[%0d]", i), vecs[i].exp_req_valid, vecs[i].exp_req_addr);
            checkHead($sformatf("fill[%0d]", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Redirect with latency 3: three fetches in flight (one responding in
        // the redirect cycle) plus one buffered, which is all the credit
        // DEPTH=4 allows. All three stale responses must be dropped.
        doReset();
        mem_latency = 3;
        mem_ready   = 1'b1;
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c3", 1'b1, 32'h0C);
        applyStimulus(1'b1, 32'h40, 1'b0);
        checkReq("redir.c4", 1'b0, 32'h10);
        checkHead("redir.c4", 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c5", 1'b1, 32'h40);
        checkHead("redir.c5", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c6", 1'b1, 32'h44);
        checkHead("redir.c6", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c7", 1'b1, 32'h48);
        checkHead("redir.c7", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c8", 1'b1, 32'h4C);
        checkHead("redir.c8", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("redir.c9", 1'b0, 32'h50);
        checkHead("redir.c9", 1'b1, 32'h40);

        // Redirect coinciding with a response and a pop, 1-cycle memory.
        doReset();
        mem_latency = 1;
        mem_ready   = 1'b1;
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h83, 1'b1);
        checkReq("rsp_redir.c2", 1'b0, 32'h08);
        checkHead("rsp_redir.c2", 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("rsp_redir.c3", 1'b1, 32'h80);
        checkHead("rsp_redir.c3", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkHead("rsp_redir.c4", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkHead("rsp_redir.c5", 1'b1, 32'h80);

        // Full queue, then reset asserted between clock edges.
        doReset();
        mem_latency = 1;
        mem_ready   = 1'b1;
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
        checkHead("full.c5", 1'b1, 32'h0);
        checkReq("full.c5", 1'b0, 32'h10);
        #1;
        reset = 1'b1;
        #1;
        checkHead("async_reset", 1'b0, 32'h0);
        checkReq("async_reset", 1'b0, 32'h0);

        // After release: a stray response with nothing outstanding is
        // ignored, and ready held low for five cycles freezes the request.
        doReset();
        mem_latency = 1;
        mem_ready   = 1'b0;
        stray_rsp   = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        stray_rsp   = 1'b0;
        checkReq("stall.c0", 1'b1, 32'h0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checkReq($sformatf("stall.c%0d", i), 1'b1, 32'h0);
            checkHead($sformatf("stall.c%0d", i), 1'b0, 32'h0);
        end
        mem_ready = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("stall.c5", 1'b1, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkReq("stall.c6", 1'b1, 32'h4);
        checkHead("stall.c6", 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkHead("stall.c7", 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
